// File: rtl/dff_checker_if.sv
// Observation bus between a flip-flop under check and its checker.
// master drives the observed pins, slave (the checker) returns its verdicts.
interface dff_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             Cl;
  logic             Pr;
  logic             d;
  logic             q;
  logic             exp_q;
  logic             mismatch;
  logic             err_flag;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, Cl, Pr, d, q,
    input  exp_q, mismatch, err_flag, chk_cnt, err_cnt
  );

  modport slave (
    input  en, Cl, Pr, d, q,
    output exp_q, mismatch, err_flag, chk_cnt, err_cnt
  );
endinterface

// File: rtl/dff_checker.sv
// Falling-edge checker for a D flip-flop with active-low clear/preset:
// predicts q one period ahead and counts compares and mismatches.
module dff_checker #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  dff_checker_if.slave bus
);
  // state | meaning
  // IDLE  | disabled, everything held
  // ARM   | first enabled edge: load prediction, no compare
  // CHECK | compare q against last prediction, then reload
  typedef enum logic [1:0] {IDLE, ARM, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             exp_q_q;
  logic             exp_d;
  logic             mismatch_q;
  logic             err_flag_q;
  logic [CNT_W-1:0] chk_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             q_ok;

  // Clear wins over preset.
  assign exp_d = !bus.Cl ? 1'b0 : (!bus.Pr ? 1'b1 : bus.d);

  // An unknown q makes this compare unknown, which lands in the mismatch branch.
  assign q_ok = (bus.q == exp_q_q);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      exp_q_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_flag_q <= 1'b0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en) state_q <= ARM;
        end
        ARM: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else begin
            exp_q_q <= exp_d;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else begin
            exp_q_q <= exp_d;
            if (chk_cnt_q != CNT_MAX) chk_cnt_q <= chk_cnt_q + CNT_W'(1);
            if (q_ok) begin
              mismatch_q <= 1'b0;
            end else begin
              mismatch_q <= 1'b1;
              err_flag_q <= 1'b1;
              if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.exp_q    = exp_q_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err_flag = err_flag_q;
  assign bus.chk_cnt  = chk_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of the check and error counters.
REQ-002 clk  input  1  single clock; all state updates on the falling edge of clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  check enable; 1 = observe and compare, 0 = idle.
REQ-005 Cl  input  1  observed active-low clear of the device under check.
REQ-006 Pr  input  1  observed active-low preset of the device under check.
REQ-007 d  input  1  observed data input of the device under check.
REQ-008 q  input  1  observed output of the device under check.
REQ-009 exp_q  output  1  predicted q for the current cycle.
REQ-010 mismatch  output  1  one-cycle pulse, q differed from exp_q at the last compare.
REQ-011 err_flag  output  1  sticky, set on the first mismatch.
REQ-012 chk_cnt  output  CNT_W  number of compares performed, saturating.
REQ-013 err_cnt  output  CNT_W  number of mismatches, saturating.

Function
REQ-014 The checker SHALL predict the device's next output from Cl, Pr and d sampled on each falling edge of clk.
- Priority: Cl==0 gives 0.
- Else Pr==0 gives 1.
- Else the prediction is d.
REQ-015 The checker SHALL hold a three-state FSM: IDLE, ARM, CHECK.
REQ-016 IDLE SHALL go to ARM on a falling edge with en==1; otherwise it SHALL stay in IDLE and hold all counters and flags.
REQ-017 In ARM the checker SHALL load exp_q with the prediction and go to CHECK, with no compare.
REQ-018 In CHECK, on each falling edge with en==1, the checker SHALL:
- compare q (sampled at that edge) against the registered exp_q;
- then load exp_q with the new prediction;
- stay in CHECK.
REQ-019 Compare latency SHALL be one clk period: inputs sampled at edge k are checked against q sampled at edge k+1.
REQ-020 Each compare SHALL increment chk_cnt by 1 and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-021 On a failed compare the checker SHALL:
- drive mismatch=1 for exactly one period;
- increment err_cnt, saturating at 2^CNT_W-1;
- set err_flag.
REQ-022 A q value of X or Z at a compare SHALL count as a mismatch.
REQ-023 Once set, err_flag SHALL stay at 1 until rst, independent of en.
REQ-024 en==0 sampled in ARM or CHECK SHALL return the FSM to IDLE with no compare that edge. Counters, err_flag and exp_q SHALL hold; mismatch SHALL be 0.
REQ-025 Re-enabling from IDLE SHALL pass through ARM again, so the first edge after re-enable never compares.
REQ-026 If chk_cnt is saturated and a mismatch occurs, err_cnt SHALL still increment up to its own saturation.
REQ-027 Cl==0 and Pr==0 asserted together SHALL predict 0 (clear wins).

Reset
REQ-028 rst==1 SHALL immediately, without a clock edge, force:
- FSM to IDLE;
- exp_q=0, mismatch=0, err_flag=0, chk_cnt=0, err_cnt=0.
REQ-029 rst asserted mid-CHECK SHALL abort any pending compare, with no count and no flag.
REQ-030 Deasserting rst SHALL take effect from the next falling edge only.

Verification
REQ-031 Bench SHALL cover clear: en=1, Cl=0 Pr=1 d=0, correct device q=0 -> after 1 ARM plus 4 compare edges: chk_cnt=4, err_cnt=0, err_flag=0.
REQ-032 Bench SHALL cover the sequence {d,Cl,Pr} = 001, 010, 011, 101, 110, 111, one per falling edge, correct device -> exp_q = 0, 1, 0, 0, 1, 1; no mismatch.
REQ-033 Bench SHALL cover a fault: force q=1 while exp_q=0 on one compare -> mismatch high for exactly one period, err_cnt=1, err_flag=1 and held after q recovers.
REQ-034 Bench SHALL cover saturation: CNT_W=2, 6 consecutive failed compares -> chk_cnt=3, err_cnt=3, no wrap.
REQ-035 Bench SHALL cover en gap: drop en for 3 edges mid-CHECK, then restore -> counters frozen during the gap; first edge after restore is ARM with no compare; compares resume the next edge.
REQ-036 Bench SHALL cover async reset: pulse rst between clock edges with err_cnt=2 -> all outputs 0 before the next edge; FSM in IDLE.
